shift_rows_unit: RTL and testbench
==================================

Name: shift_rows_unit

Overview:
- Parametrised, registered ShiftRows/InvShiftRows engine for the AES/Rijndael round datapath.
- Supports NB = 4, 6 or 8 columns, with the forward or inverse mode selected per beat.
- Sits between the SubBytes/InvSubBytes stage and the MixColumns stage.
- Valid/ready on both sides, with a 2-entry output buffer for back-pressure; replaces the fixed 128-bit combinational inverse permutation.

Parameters:
- NB, 4, number of state columns (legal values 4, 6, 8); data width is 32*NB.
- CNT_W, 16, width of the processed-beat counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous clear of buffered beats; does not clear beat_count.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_inv  input  1  mode for this beat: 0 = ShiftRows, 1 = InvShiftRows.
- in_data  input  32*NB  state; byte b = r + 4c sits at bits [8b+7:8b] (r = row 0..3, c = column).
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_inv  output  1  mode carried with the beat.
- out_data  output  32*NB  permuted state.
- beat_count  output  CNT_W  number of beats accepted since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Row shift offsets: C0 = 0, C1 = 1. C2 = 2 and C3 = 3 for NB = 4 or 6; C2 = 3 and C3 = 4 for NB = 8.
- Forward permutation: out[r][c] = in[r][(c + Cr) mod NB].
- Inverse permutation: out[r][c] = in[r][(c - Cr + NB) mod NB].
- Illegal NB is a compile-time error (elaboration assertion).
- The permutation is pure wiring feeding the buffer; no arithmetic.
- Buffer: 2-entry FIFO (data + inv), with registered count in {0, 1, 2}.
- Push occurs when in_valid and in_ready; pop occurs when out_valid and out_ready.
- in_ready = (count != 2). It is registered-state-derived, with no combinational path from out_ready.
- out_valid = (count != 0); out_data/out_inv = head entry.
- Latency: a beat accepted at edge N is visible on out_* after edge N, i.e. one cycle, when the buffer was empty.
- Push and pop in the same cycle: count unchanged, order preserved. When count = 1, the new beat becomes head after the pop.
- Full (count = 2): in_ready is low and no push occurs, even if a pop happens that cycle.
- Empty: out_valid is low. out_data holds its last value and must not be relied upon.
- Held outputs: while out_valid is high and out_ready is low, out_data and out_inv hold stable.
- beat_count increments by 1 on every push and wraps modulo 2^CNT_W.
- flush: count goes to 0 next cycle. A push in the same cycle is discarded; beat_count still counts it.
- rst: count = 0, head/tail pointers = 0, beat_count = 0, out_data = 0, out_inv = 0. Therefore in_ready = 1 and out_valid = 0 in the first cycle after reset.
- rst mid-transfer: all buffered beats are dropped; rst has priority over flush and push.

Decomposition:
- Package aes_pkg:
  - localparam function shift_offset(nb, row) returning Cr.
  - Byte/word typedefs: byte_t = logic [7:0]; state_t parametrised by NB via a packed array of byte_t.
  - MODE_FWD = 1'b0, MODE_INV = 1'b1.
- Sub-module shift_rows_perm (combinational, parameters NB and INV): one instance per mode, with the output muxed by in_inv before the FIFO write.
- FIFO storage is kept inline.

Test Plan:
1. Forward, NB = 4, in_inv = 0. Input bytes b0..b15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 (b0 at [7:0]). Expected output, one cycle later: d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, with out_inv = 0.
2. Inverse round trip, NB = 4, in_inv = 1. Feed the output of scenario 1 → scenario 1's input returns exactly. Then sweep 1000 random beats with random modes against a reference model → zero mismatches.
3. NB = 8, forward, bytes b = 0x00..0x1F. Row 2 output = input columns 3,4,5,6,7,0,1,2, i.e. bytes 0x0E,0x12,0x16,0x1A,0x1E,0x02,0x06,0x0A. Row 3 is rotated by 4; inverse restores the input. Repeat for NB = 6 with offsets 1, 2, 3.
4. Back-pressure: out_ready = 0 and three beats A, B, C offered back-to-back. A and B accepted; in_ready goes low after B; C is held. out_data = A holds stable. Release out_ready → order A, B, C; beat_count = 3.
5. Simultaneous push/pop at count = 1 for 100 cycles with continuous valid and ready → one beat per cycle throughput, count stays 1, no loss or reordering.
6. flush with count = 2 and a concurrent push → out_valid = 0 next cycle; beat_count has still incremented. Then rst asserted mid-stream → all outputs at reset values next cycle, beat_count = 0. Also check beat_count wraps with CNT_W = 4 after 16 pushes → value 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types and the ShiftRows row-offset table used by the
// round engines.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Rijndael row offsets: rows 2 and 3 shift further once the state is 8 columns wide.
    function automatic int shift_offset(input int nb, input int row);
        int off;
        case (row)
            0:       off = 0;
            1:       off = 1;
            2:       off = (nb == 8) ? 3 : 2;
            default: off = (nb == 8) ? 4 : 3;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Fixed ShiftRows (INV = 0) or InvShiftRows (INV = 1) byte permutation for an
// NB-column state; pure wiring.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB  = 4,
    parameter bit INV = 1'b0
) (
    input  logic [32*NB-1:0] state_i,
    output logic [32*NB-1:0] state_o
);

    typedef byte_t [4*NB-1:0] state_t;

    state_t inBytes;
    state_t outBytes;

    assign inBytes = state_i;
    assign state_o = outBytes;

    // Byte b = r + 4c; each output byte picks its source column from the row offset.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int CR  = shift_offset(NB, r);
            localparam int SRC = INV ? ((c - CR + NB) % NB) : ((c + CR) % NB);
            assign outBytes[r + 4*c] = inBytes[r + 4*SRC];
        end
    end

endmodule

// File: rtl/shift_rows_unit.sv
// Registered ShiftRows/InvShiftRows stage with per-beat mode select and a
// 2-entry output FIFO providing valid/ready back-pressure.
module shift_rows_unit
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [32*NB-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_inv,
    output logic [32*NB-1:0] out_data,
    output logic [CNT_W-1:0] beat_count
);

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_unit: NB must be 4, 6 or 8");
    end

    logic [32*NB-1:0] fwdData;
    logic [32*NB-1:0] invData;
    logic [32*NB-1:0] permData;

    shift_rows_perm #(.NB(NB), .INV(MODE_FWD)) u_perm_fwd (
        .state_i (in_data),
        .state_o (fwdData)
    );

    shift_rows_perm #(.NB(NB), .INV(MODE_INV)) u_perm_inv (
        .state_i (in_data),
        .state_o (invData)
    );

    assign permData = (in_inv == MODE_INV) ? invData : fwdData;

    logic [1:0][32*NB-1:0] data_q, data_d;
    logic [1:0]            inv_q, inv_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic [CNT_W-1:0]      beat_count_q, beat_count_d;
    logic                  push;
    logic                  pop;

    // Handshake flags come only from registered count, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data   = data_q[head_q];
    assign out_inv    = inv_q[head_q];
    assign beat_count = beat_count_q;

    always_comb begin
        data_d       = data_q;
        inv_d        = inv_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        beat_count_d = push ? beat_count_q + CNT_W'(1) : beat_count_q;

        // A flush drops everything, including a beat pushed this cycle; tail realigns to head.
        if (flush) begin
            count_d = 2'd0;
            tail_d  = head_q;
        end else begin
            if (push) begin
                data_d[tail_q] = permData;
                inv_d[tail_q]  = in_inv;
                tail_d         = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= '0;
            inv_q        <= '0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            count_q      <= 2'd0;
            beat_count_q <= '0;
        end else begin
            data_q       <= data_d;
            inv_q        <= inv_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            beat_count_q <= beat_count_d;
        end
    end

endmodule

// File: tb/tb_shift_rows_unit.sv
// Self-checking bench for shift_rows_unit: known vectors, NB = 4/6/8 permutations,
// random traffic against a byte-level reference model, back-pressure, flush and reset.
module tb_shift_rows_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;

    logic         iv4, ir4, ii4, ov4, or4, oi4;
    logic [127:0] id4, od4;
    logic [15:0]  bc4;

    logic         ivw, irw, iiw, ovw, orw, oiw;
    logic [127:0] idw, odw;
    logic [3:0]   bcw;

    logic         iv8, ir8, ii8, ov8, or8, oi8;
    logic [255:0] id8, od8;
    logic [15:0]  bc8;

    logic         iv6, ir6, ii6, ov6, or6, oi6;
    logic [191:0] id6, od6;
    logic [15:0]  bc6;

    int total = 0;
    int bad   = 0;

    shift_rows_unit #(.NB(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv4), .in_ready(ir4), .in_inv(ii4),
        .in_data(id4), .out_valid(ov4), .out_ready(or4), .out_inv(oi4), .out_data(od4),
        .beat_count(bc4)
    );

    shift_rows_unit #(.NB(4), .CNT_W(4)) u_dutw (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(ivw), .in_ready(irw), .in_inv(iiw),
        .in_data(idw), .out_valid(ovw), .out_ready(orw), .out_inv(oiw), .out_data(odw),
        .beat_count(bcw)
    );

    shift_rows_unit #(.NB(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv8), .in_ready(ir8), .in_inv(ii8),
        .in_data(id8), .out_valid(ov8), .out_ready(or8), .out_inv(oi8), .out_data(od8),
        .beat_count(bc8)
    );

    shift_rows_unit #(.NB(6), .CNT_W(16)) u_dut6 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv6), .in_ready(ir6), .in_inv(ii6),
        .in_data(id6), .out_valid(ov6), .out_ready(or6), .out_inv(oi6), .out_data(od6),
        .beat_count(bc6)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Reference: treat the state as a 4 x nb byte matrix and rotate each row.
    function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d, input logic inv);
        logic [255:0] o;
        int off [4];
        int src;
        o = '0;
        off[0] = 0;
        off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb == 8) ? 4 : 3;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
                o[8*(r + 4*c) +: 8] = d[8*(r + 4*src) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] ref4(input logic [127:0] d, input logic inv);
        logic [255:0] t;
        t = ref_perm(4, {128'b0, d}, inv);
        return t[127:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        iv4 = 1'b0; ii4 = 1'b0; or4 = 1'b1; id4 = '0;
        ivw = 1'b0; iiw = 1'b0; orw = 1'b1; idw = '0;
        iv8 = 1'b0; ii8 = 1'b0; or8 = 1'b1; id8 = '0;
        iv6 = 1'b0; ii6 = 1'b0; or6 = 1'b1; id6 = '0;
        step();
        step();
        rst = 1'b0;
        total++; if (ir4 !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", ir4); end
        total++; if (ov4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", ov4); end
        total++; if (od4 !== 128'b0) begin bad++; $display("[TB] FAIL reset_out_data got=%h want=0", od4); end
        total++; if (oi4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_inv got=%b want=0", oi4); end
        total++; if (bc4 !== 16'd0) begin bad++; $display("[TB] FAIL reset_beat_count got=%0d want=0", bc4); end
        total++; if ({irw, ovw, oiw, odw, bcw} !== {1'b1, 1'b0, 1'b0, 128'b0, 4'd0}) begin
            bad++; $display("[TB] FAIL reset_wrap_unit got=%b%b%b %h %0d want=100 0 0", irw, ovw, oiw, odw, bcw);
        end
        total++; if ({ir8, ov8, oi8, od8, bc8} !== {1'b1, 1'b0, 1'b0, 256'b0, 16'd0}) begin
            bad++; $display("[TB] FAIL reset_nb8_unit got=%b%b%b %h %0d want=100 0 0", ir8, ov8, oi8, od8, bc8);
        end
        total++; if ({ir6, ov6, oi6, od6, bc6} !== {1'b1, 1'b0, 1'b0, 192'b0, 16'd0}) begin
            bad++; $display("[TB] FAIL reset_nb6_unit got=%b%b%b %h %0d want=100 0 0", ir6, ov6, oi6, od6, bc6);
        end
    endtask

    localparam logic [127:0] VEC_IN  = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
    localparam logic [127:0] VEC_OUT = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

    task automatic test_forward_vector();
        or4 = 1'b0; iv4 = 1'b1; ii4 = 1'b0; id4 = VEC_IN;
        step();
        iv4 = 1'b0;
        total++; if (ov4 !== 1'b1) begin bad++; $display("[TB] FAIL fwd_vec_valid got=%b want=1", ov4); end
        total++; if (od4 !== VEC_OUT) begin bad++; $display("[TB] FAIL fwd_vec_data got=%h want=%h", od4, VEC_OUT); end
        total++; if (oi4 !== 1'b0) begin bad++; $display("[TB] FAIL fwd_vec_inv got=%b want=0", oi4); end
        or4 = 1'b1;
        step();
        total++; if (ov4 !== 1'b0) begin bad++; $display("[TB] FAIL fwd_vec_drain got=%b want=0", ov4); end
    endtask

    task automatic test_inverse_random();
        logic [128:0] sb[$];
        logic [128:0] exp;
        int pushed;
        int cyc;
        iv4 = 1'b1; ii4 = 1'b1; id4 = VEC_OUT;
        step();
        iv4 = 1'b0;
        total++; if (od4 !== VEC_IN) begin bad++; $display("[TB] FAIL inv_roundtrip_data got=%h want=%h", od4, VEC_IN); end
        total++; if (oi4 !== 1'b1) begin bad++; $display("[TB] FAIL inv_roundtrip_inv got=%b want=1", oi4); end
        step();

        pushed = 0;
        cyc = 0;
        while (cyc < 6000 && (pushed < 1000 || sb.size() != 0)) begin
            iv4 = (pushed < 1000) && ($urandom_range(0, 3) != 0);
            or4 = ($urandom_range(0, 3) != 0);
            ii4 = 1'($urandom_range(0, 1));
            id4 = rand128();
            total++; if (ov4 !== (sb.size() != 0)) begin
                bad++; $display("[TB] FAIL rand_out_valid got=%b want=%b", ov4, sb.size() != 0);
            end
            total++; if (ir4 !== (sb.size() != 2)) begin
                bad++; $display("[TB] FAIL rand_in_ready got=%b want=%b", ir4, sb.size() != 2);
            end
            if (ov4 && or4 && sb.size() != 0) begin
                exp = sb.pop_front();
                total++; if ({oi4, od4} !== exp) begin
                    bad++; $display("[TB] FAIL rand_beat got=%b/%h want=%b/%h", oi4, od4, exp[128], exp[127:0]);
                end
            end
            if (iv4 && ir4) begin
                sb.push_back({ii4, ref4(id4, ii4)});
                pushed++;
            end
            step();
            cyc++;
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        total++; if (pushed != 1000 || sb.size() != 0) begin
            bad++; $display("[TB] FAIL rand_complete got=%0d pushed %0d left want=1000 pushed 0 left", pushed, sb.size());
        end
    endtask

    task automatic test_nb8();
        logic [255:0] src;
        logic [255:0] fwd;
        for (int i = 0; i < 32; i++) src[8*i +: 8] = 8'(i);
        fwd = ref_perm(8, src, 1'b0);
        id8 = src; ii8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        step();
        total++; if (od8 !== fwd) begin bad++; $display("[TB] FAIL nb8_fwd got=%h want=%h", od8, fwd); end
        for (int c = 0; c < 8; c++) begin
            total++; if (od8[8*(2 + 4*c) +: 8] !== 8'(2 + 4*((c + 3) % 8))) begin
                bad++; $display("[TB] FAIL nb8_row2 col=%0d got=%h want=%h", c, od8[8*(2 + 4*c) +: 8], 8'(2 + 4*((c + 3) % 8)));
            end
            total++; if (od8[8*(3 + 4*c) +: 8] !== 8'(3 + 4*((c + 4) % 8))) begin
                bad++; $display("[TB] FAIL nb8_row3 col=%0d got=%h want=%h", c, od8[8*(3 + 4*c) +: 8], 8'(3 + 4*((c + 4) % 8)));
            end
        end
        id8 = fwd; ii8 = 1'b1;
        step();
        iv8 = 1'b0;
        total++; if ({oi8, od8} !== {1'b1, src}) begin bad++; $display("[TB] FAIL nb8_inv got=%b/%h want=1/%h", oi8, od8, src); end
        total++; if (ir8 !== 1'b1) begin bad++; $display("[TB] FAIL nb8_ready got=%b want=1", ir8); end
        step();
    endtask

    task automatic test_nb6();
        logic [191:0] src;
        logic [255:0] t;
        logic [191:0] fwd;
        for (int i = 0; i < 24; i++) src[8*i +: 8] = 8'(i);
        t = ref_perm(6, {64'b0, src}, 1'b0);
        fwd = t[191:0];
        id6 = src; ii6 = 1'b0; iv6 = 1'b1; or6 = 1'b1;
        step();
        total++; if (od6 !== fwd) begin bad++; $display("[TB] FAIL nb6_fwd got=%h want=%h", od6, fwd); end
        for (int r = 1; r < 4; r++) begin
            for (int c = 0; c < 6; c++) begin
                total++; if (od6[8*(r + 4*c) +: 8] !== 8'(r + 4*((c + r) % 6))) begin
                    bad++; $display("[TB] FAIL nb6_row r=%0d c=%0d got=%h want=%h", r, c, od6[8*(r + 4*c) +: 8], 8'(r + 4*((c + r) % 6)));
                end
            end
        end
        id6 = fwd; ii6 = 1'b1;
        step();
        iv6 = 1'b0;
        total++; if ({oi6, od6} !== {1'b1, src}) begin bad++; $display("[TB] FAIL nb6_inv got=%b/%h want=1/%h", oi6, od6, src); end
        total++; if (ir6 !== 1'b1) begin bad++; $display("[TB] FAIL nb6_ready got=%b want=1", ir6); end
        step();
    endtask

    task automatic test_back_pressure();
        logic [127:0] a, b, c;
        a = rand128(); b = rand128(); c = rand128();
        rst = 1'b1;
        step();
        rst = 1'b0;
        or4 = 1'b0; iv4 = 1'b1; ii4 = 1'b0; id4 = a;
        step();
        total++; if ({ir4, ov4, od4} !== {1'b1, 1'b1, ref4(a, 1'b0)}) begin
            bad++; $display("[TB] FAIL bp_after_a got=%b%b %h want=11 %h", ir4, ov4, od4, ref4(a, 1'b0));
        end
        ii4 = 1'b1; id4 = b;
        step();
        total++; if (ir4 !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_ready got=%b want=0", ir4); end
        ii4 = 1'b0; id4 = c;
        step();
        step();
        total++; if ({ir4, oi4, od4} !== {1'b0, 1'b0, ref4(a, 1'b0)}) begin
            bad++; $display("[TB] FAIL bp_hold_a got=%b%b %h want=00 %h", ir4, oi4, od4, ref4(a, 1'b0));
        end
        or4 = 1'b1;
        step();
        total++; if ({oi4, od4} !== {1'b1, ref4(b, 1'b1)}) begin
            bad++; $display("[TB] FAIL bp_order_b got=%b/%h want=1/%h", oi4, od4, ref4(b, 1'b1));
        end
        step();
        iv4 = 1'b0;
        total++; if ({oi4, od4} !== {1'b0, ref4(c, 1'b0)}) begin
            bad++; $display("[TB] FAIL bp_order_c got=%b/%h want=0/%h", oi4, od4, ref4(c, 1'b0));
        end
        step();
        total++; if (ov4 !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained got=%b want=0", ov4); end
        total++; if (bc4 !== 16'd3) begin bad++; $display("[TB] FAIL bp_beat_count got=%0d want=3", bc4); end
    endtask

    task automatic test_back_to_back();
        logic [128:0] sb[$];
        logic [128:0] exp;
        or4 = 1'b0; iv4 = 1'b1; ii4 = 1'($urandom_range(0, 1)); id4 = rand128();
        sb.push_back({ii4, ref4(id4, ii4)});
        step();
        or4 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            ii4 = 1'($urandom_range(0, 1));
            id4 = rand128();
            total++; if ({ov4, ir4} !== 2'b11) begin bad++; $display("[TB] FAIL b2b_count_one cyc=%0d got=%b%b want=11", k, ov4, ir4); end
            exp = sb.pop_front();
            total++; if ({oi4, od4} !== exp) begin
                bad++; $display("[TB] FAIL b2b_beat cyc=%0d got=%b/%h want=%b/%h", k, oi4, od4, exp[128], exp[127:0]);
            end
            sb.push_back({ii4, ref4(id4, ii4)});
            step();
        end
        iv4 = 1'b0;
        exp = sb.pop_front();
        total++; if ({ov4, oi4, od4} !== {1'b1, exp}) begin
            bad++; $display("[TB] FAIL b2b_last got=%b%b/%h want=1%b/%h", ov4, oi4, od4, exp[128], exp[127:0]);
        end
        step();
        total++; if (ov4 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drained got=%b want=0", ov4); end
    endtask

    task automatic test_flush_reset();
        logic [15:0]  bcBefore;
        logic [127:0] d, e;
        d = rand128(); e = rand128();
        bcBefore = bc4;
        or4 = 1'b0; iv4 = 1'b1; ii4 = 1'b0; id4 = rand128();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; iv4 = 1'b0;
        total++; if ({ov4, ir4} !== 2'b01) begin bad++; $display("[TB] FAIL flush_full got=%b%b want=01", ov4, ir4); end
        total++; if (bc4 !== 16'(bcBefore + 16'd2)) begin bad++; $display("[TB] FAIL flush_full_count got=%0d want=%0d", bc4, bcBefore + 16'd2); end
        iv4 = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; iv4 = 1'b0;
        total++; if (ov4 !== 1'b0) begin bad++; $display("[TB] FAIL flush_push_valid got=%b want=0", ov4); end
        total++; if (bc4 !== 16'(bcBefore + 16'd4)) begin bad++; $display("[TB] FAIL flush_push_count got=%0d want=%0d", bc4, bcBefore + 16'd4); end
        iv4 = 1'b1; ii4 = 1'b1; id4 = d;
        step();
        ii4 = 1'b0; id4 = e;
        step();
        iv4 = 1'b0; or4 = 1'b1;
        total++; if ({oi4, od4} !== {1'b1, ref4(d, 1'b1)}) begin
            bad++; $display("[TB] FAIL flush_after_d got=%b/%h want=1/%h", oi4, od4, ref4(d, 1'b1));
        end
        step();
        total++; if ({oi4, od4} !== {1'b0, ref4(e, 1'b0)}) begin
            bad++; $display("[TB] FAIL flush_after_e got=%b/%h want=0/%h", oi4, od4, ref4(e, 1'b0));
        end
        or4 = 1'b0; iv4 = 1'b1; ii4 = 1'b1; id4 = rand128();
        step();
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; iv4 = 1'b0;
        total++; if ({ir4, ov4, oi4} !== 3'b100) begin bad++; $display("[TB] FAIL midrst_flags got=%b%b%b want=100", ir4, ov4, oi4); end
        total++; if (od4 !== 128'b0) begin bad++; $display("[TB] FAIL midrst_data got=%h want=0", od4); end
        total++; if (bc4 !== 16'd0) begin bad++; $display("[TB] FAIL midrst_count got=%0d want=0", bc4); end
    endtask

    task automatic test_count_wrap();
        ivw = 1'b1; orw = 1'b1;
        for (int i = 0; i < 16; i++) begin
            iiw = 1'($urandom_range(0, 1));
            idw = rand128();
            step();
            if (i == 14) begin
                total++; if (bcw !== 4'd15) begin bad++; $display("[TB] FAIL wrap_fifteen got=%0d want=15", bcw); end
            end
        end
        ivw = 1'b0;
        total++; if (bcw !== 4'd0) begin bad++; $display("[TB] FAIL wrap_zero got=%0d want=0", bcw); end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        test_reset();
        test_forward_vector();
        test_inverse_random();
        test_nb8();
        test_nb6();
        test_back_pressure();
        test_back_to_back();
        test_flush_reset();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
